// File: rtl/coprocessor_engine.sv
// coprocessor_engine: byte-serial frame transformer (pass, reverse, upper-case, running checksum) with valid/ready handshake
module coprocessor_engine #(
  parameter int NBYTES = 18,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(NBYTES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NBYTES-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [1:0]          mode,
  output logic [8*NBYTES-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count
);
  typedef enum logic [1:0] {IDLE, PROC, OUT} state_t;
  state_t state;
  logic [8*NBYTES-1:0] in_buf, out_buf;
  logic [1:0] mode_r;
  logic [IDX_W-1:0] idx;
  logic [7:0] acc, fwd, rev, sum, res;
  logic last;
  always_comb begin
    fwd = '0;
    rev = '0;
    for (int k = 0; k < NBYTES; k++)
      if (idx == IDX_W'(k)) begin
        fwd = in_buf[8*k +: 8];
        rev = in_buf[8*(NBYTES-1-k) +: 8];
      end
    sum = acc + fwd;
    res = mode_r == 2'd0 ? fwd :
          mode_r == 2'd1 ? rev :
          mode_r == 2'd2 ? ((fwd >= 8'h61 && fwd <= 8'h7a) ? fwd - 8'h20 : fwd) : sum;
    last = idx == IDX_W'(NBYTES - 1);
  end
  assign din_ready = state == IDLE;
  assign busy = !din_ready;
  assign dout_valid = state == OUT;
  assign dout = out_buf;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      in_buf <= '0;
      out_buf <= '0;
      mode_r <= '0;
      frame_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (din_valid) begin
          in_buf <= din;
          mode_r <= mode;
          idx <= '0;
          acc <= '0;
          state <= PROC;
        end
        PROC: begin
          for (int k = 0; k < NBYTES; k++)
            if (idx == IDX_W'(k)) out_buf[8*k +: 8] <= res;
          acc <= sum;
          idx <= idx + IDX_W'(1);
          if (last) state <= OUT;
        end
        OUT: if (dout_ready) begin
          frame_count <= frame_count + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coprocessor_engine.sv
// tb_coprocessor_engine: directed checks of the frame coprocessor at NBYTES=4 (CNT_W 16 and 2) and NBYTES=1
module tb_coprocessor_engine;
  logic clk = 0, rst = 0;
  logic [31:0] din = '0;
  logic din_valid = 0, dout_ready = 0;
  logic [1:0] mode = '0;
  logic [31:0] dout, dout_c;
  logic din_ready, dout_valid, busy, din_ready_c, dout_valid_c, busy_c;
  logic [15:0] frame_count;
  logic [1:0] frame_count_c;
  logic [7:0] din2 = '0, dout2;
  logic v2 = 0, r2 = 0, rdy2, dv2, busy2;
  logic [1:0] m2 = '0;
  logic [15:0] cnt2;
  int ntests = 0, nfail = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  coprocessor_engine #(.NBYTES(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .mode(mode), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_count(frame_count));
  coprocessor_engine #(.NBYTES(4), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_c), .mode(mode), .dout(dout_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready),
    .busy(busy_c), .frame_count(frame_count_c));
  coprocessor_engine #(.NBYTES(1), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .din(din2), .din_valid(v2),
    .din_ready(rdy2), .mode(m2), .dout(dout2), .dout_valid(dv2), .dout_ready(r2),
    .busy(busy2), .frame_count(cnt2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (!dout_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask
  task automatic consume(input string tag);
    dout_ready = 1;
    tick();
    dout_ready = 0;
    exp_cnt++;
    chk({tag, "_cnt"}, 64'(frame_count), 64'(exp_cnt));
    chk({tag, "_cnt_w2"}, 64'(frame_count_c), 64'(exp_cnt % 4));
    chk({tag, "_rdy_after"}, {din_ready, busy, dout_valid}, 3'b100);
  endtask
  task automatic run_frame(input string tag, input logic [31:0] d, input logic [1:0] m, input logic [31:0] exp);
    din = d;
    mode = m;
    din_valid = 1;
    for (int i = 0; i < 50 && !din_ready; i++) tick();
    chk({tag, "_din_ready"}, 64'(din_ready), 64'd1);
    tick();
    din_valid = 0;
    chk({tag, "_busy"}, {din_ready, busy}, 2'b01);
    wait_valid(tag, 4);
    chk({tag, "_dout"}, 64'(dout), 64'(exp));
    consume(tag);
  endtask
  initial begin
    tick();
    tick();
    chk("reset_outs", {dout, dout_valid, din_ready, busy}, {32'h0, 3'b010});
    chk("reset_cnt", 64'(frame_count), 64'd0);
    rst = 1;
    run_frame("m0", 32'h64636261, 2'd0, 32'h64636261);
    run_frame("m1", 32'h64636261, 2'd1, 32'h61626364);
    run_frame("m2", 32'h64636261, 2'd2, 32'h44434241);
    run_frame("m3", 32'h64636261, 2'd3, 32'h8A26C361);
    run_frame("m2_nonletter", 32'h7B7A6040, 2'd2, 32'h7B5A6040);
    din = 32'h64636261;
    mode = 2'd1;
    din_valid = 1;
    tick();
    din = 32'h11223344;
    mode = 2'd0;
    wait_valid("bp_first", 4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_dout_hold", 64'(dout), 64'h61626364);
      chk("bp_flags_hold", {dout_valid, din_ready, busy}, 3'b101);
      tick();
    end
    consume("bp_release");
    run_frame("bp_second", 32'h11223344, 2'd0, 32'h11223344);
    din = 32'h64636261;
    mode = 2'd0;
    din_valid = 1;
    tick();
    din_valid = 0;
    tick();
    mode = 2'd1;
    din = 32'hdeadbeef;
    wait_valid("modechg", 3);
    chk("modechg_dout", 64'(dout), 64'h64636261);
    consume("modechg");
    din = 32'h64636261;
    mode = 2'd3;
    din_valid = 1;
    tick();
    din_valid = 0;
    tick();
    tick();
    rst = 0;
    tick();
    rst = 1;
    exp_cnt = 0;
    chk("rst_mid_outs", {dout, dout_valid, din_ready, busy}, {32'h0, 3'b010});
    chk("rst_mid_cnt", {frame_count, frame_count_c}, 18'h0);
    run_frame("post_rst", 32'h64636261, 2'd2, 32'h44434241);
    for (int i = 0; i < 4; i++) run_frame("wrap", 32'h04030201, 2'd3, 32'h0A060301);
    chk("wrap_final_w2", 64'(frame_count_c), 64'd1);
    din2 = 8'hFF;
    m2 = 2'd3;
    v2 = 1;
    tick();
    v2 = 0;
    chk("n1_busy", {rdy2, busy2, dv2}, 3'b010);
    tick();
    chk("n1_valid_lat1", 64'(dv2), 64'd1);
    chk("n1_dout", 64'(dout2), 64'hFF);
    r2 = 1;
    tick();
    r2 = 0;
    chk("n1_cnt", 64'(cnt2), 64'd1);
    din2 = 8'h71;
    m2 = 2'd2;
    v2 = 1;
    tick();
    v2 = 0;
    tick();
    chk("n1_upper", {dv2, dout2}, {1'b1, 8'h51});
    r2 = 1;
    tick();
    din2 = 8'h05;
    m2 = 2'd3;
    v2 = 1;
    tick();
    v2 = 0;
    r2 = 0;
    tick();
    chk("n1_acc_clear", {dv2, dout2}, {1'b1, 8'h05});
    chk("n1_cnt2", 64'(cnt2), 64'd2);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/coprocessor_engine.md
# coprocessor_engine

Parametrised frame coprocessor that sits between the UART receive frame assembler and the UART transmit frame serialiser. It accepts one NBYTES-wide frame with a per-frame mode and transforms it one byte per clock: pass-through, byte reverse, ASCII upper-case or running checksum. It presents the result with a valid/ready handshake and applies backpressure to the receive side while busy. It is the successor to the fixed-width, one-cycle forwarding coprocessor and replaces its bidirectional control bus with explicit handshake and status ports.

## Interface
- NBYTES, 18: frame length in bytes; must be at least 1; byte i occupies bits [8i+7:8i], byte 0 is first on the wire.
- CNT_W, 16: width of the completed-frame counter.
- IDX_W, $clog2(NBYTES)+1: width of the internal byte index (derived, not overridden).

- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low: clears state when rst=0 at a rising clk edge.
- din  input  8*NBYTES  input frame.
- din_valid  input  1  input frame present.
- din_ready  output  1  engine can accept a frame.
- mode  input  2  transform select, sampled with din: 0 pass, 1 reverse, 2 upper, 3 checksum.
- dout  output  8*NBYTES  result frame.
- dout_valid  output  1  result frame present.
- dout_ready  input  1  downstream consumes result.
- busy  output  1  high in the PROC and OUT states.
- frame_count  output  CNT_W  number of result frames consumed downstream.

## Operation
- FSM states: IDLE, PROC, OUT.
- IDLE:
  - din_ready=1.
  - On din_valid: latch din into in_buf and mode into mode_r, clear idx to 0, go to PROC.
- PROC: each cycle, write result byte idx into out_buf, then idx++. After writing byte NBYTES-1, go to OUT.
- OUT:
  - dout_valid=1 and dout=out_buf, both held stable while dout_ready=0.
  - On dout_ready: go to IDLE and increment frame_count.
- Transforms, per output byte i, with b[k] = in_buf byte k:
  - mode 0: b[i].
  - mode 1: b[NBYTES-1-i].
  - mode 2: b[i]-8'h20 if 8'h61<=b[i]<=8'h7A, else b[i].
  - mode 3: (b[0]+...+b[i]) mod 256, using an 8-bit accumulator cleared on frame accept.
- Mode changes are taken only at accept. Changes to mode or din during PROC and OUT have no effect.
- din_ready is derived combinationally from state only. It does not depend on din_valid.
- din_valid while busy is ignored; upstream must hold the frame.
- frame_count is 8-bit-free modular arithmetic on CNT_W bits and wraps from all-ones to 0.

## Timing
- Reset (rst=0 at an edge): state=IDLE, idx=0, accumulator=0, out_buf=0, dout=0, dout_valid=0, busy=0, din_ready=1 after the edge, frame_count=0.
- Reset wins over every other event. Reset during PROC or OUT discards the frame with no output and no count.
- Latency: frame accepted at edge E; PROC occupies edges E+1..E+NBYTES; dout_valid is high after edge E+NBYTES.
- NBYTES=1: a single PROC cycle, so dout_valid is high after edge E+1.
- Throughput with dout_ready held high: one frame per NBYTES+2 cycles (accept, NBYTES PROC, one OUT cycle). din_ready returns to 1 the cycle after the consuming edge.
- No same-cycle bypass: IDLE cannot accept in the same edge as OUT completes.
- dout_valid never deasserts without dout_ready, except on reset.
- busy is identical to !din_ready.

## Test plan
All scenarios use NBYTES=4, din=32'h64636261 ("abcd").
- Mode 0, dout_ready=1: dout=32'h64636261, dout_valid rises exactly 4 edges after accept, frame_count=1.
- Mode 1, 2 and 3 back-to-back:
  - mode 1 gives 32'h61626364.
  - mode 2 gives 32'h44434241.
  - mode 3 gives 32'h8A26C361.
  - Non-letter check: mode 2 on 32'h7B7A6040 gives 32'h7B5A6040.
- Backpressure: hold dout_ready=0 for 10 cycles in OUT, with din_valid=1 and new din applied.
  - dout and dout_valid stay constant; din_ready stays 0.
  - Second frame is accepted only after the release cycle; its latency is again 4 edges.
- Mid-frame mode change: toggle mode 0 to 1 during PROC; result still 32'h64636261.
- Reset mid-operation: rst=0 for one edge at PROC idx=2.
  - After that edge: dout=0, dout_valid=0, din_ready=1, frame_count=0.
  - The next frame processes correctly.
- Counter wrap with CNT_W=2: 5 consumed frames give frame_count sequence 1,2,3,0,1. Run NBYTES=1, mode 3, din=8'hFF: result 8'hFF, latency 1 edge.
